// File: rtl/aud_ctrl.sv
// Audio record/playback sequencer: turns key pulses into recorder and player
// commands, tracks the recorded length, latches the playback configuration
// and muxes the shared SRAM port between recorder and player.
module aud_ctrl #(
   parameter int unsigned         ADDR_W   = 20,
   parameter logic [ADDR_W-1:0]   MAX_ADDR = ADDR_W'(20'hFFFFE)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_key_record,
   input  logic              i_key_play,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic [3:0]        i_speed,
   input  logic              i_fast,
   input  logic              i_interpol,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [ADDR_W-1:0] i_dsp_addr,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_dsp_start,
   output logic              o_dsp_pause,
   output logic              o_dsp_stop,
   output logic [3:0]        o_speed,
   output logic              o_fast,
   output logic              o_interpol,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic              o_has_rec,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_we_n,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REC        = 3'd1,
      S_REC_PAUSE  = 3'd2,
      S_PLAY       = 3'd3,
      S_PLAY_PAUSE = 3'd4
   } state_t;

   // Recorder reports all-ones until its first word is written.
   localparam logic [ADDR_W-1:0] ADDR_NONE = '1;

   state_t     state;
   logic       rec_valid;
   logic       rec_full;
   logic       play_done;
   logic [3:0] speed_clamped;

   // Recorder address qualifiers, player end detect and speed clamp to 1..8.
   always_comb begin
      rec_valid = (i_rec_addr != ADDR_NONE);
      rec_full  = rec_valid && (i_rec_addr >= MAX_ADDR);
      play_done = (i_dsp_addr >= o_end_addr);
      if (i_speed == 4'd0)
         speed_clamped = 4'd1;
      else if (i_speed > 4'd8)
         speed_clamped = 4'd8;
      else
         speed_clamped = i_speed;
   end

   // Sequencer: state, one-cycle command pulses, recording length, play config.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         o_rec_start <= 1'b0;
         o_rec_pause <= 1'b0;
         o_rec_stop  <= 1'b0;
         o_dsp_start <= 1'b0;
         o_dsp_pause <= 1'b0;
         o_dsp_stop  <= 1'b0;
         o_end_addr  <= '0;
         o_has_rec   <= 1'b0;
         o_speed     <= 4'd1;
         o_fast      <= 1'b0;
         o_interpol  <= 1'b0;
      end else begin
         o_rec_start <= 1'b0;
         o_rec_pause <= 1'b0;
         o_rec_stop  <= 1'b0;
         o_dsp_start <= 1'b0;
         o_dsp_pause <= 1'b0;
         o_dsp_stop  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_key_record) begin
                  state       <= S_REC;
                  o_rec_start <= 1'b1;
               end else if (i_key_play && o_has_rec) begin
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
                  o_speed     <= speed_clamped;
                  o_fast      <= i_fast;
                  o_interpol  <= i_interpol;
               end
            end
            S_REC: begin
               if (i_key_stop || rec_full) begin
                  state      <= S_IDLE;
                  o_rec_stop <= 1'b1;
                  o_has_rec  <= rec_valid;
                  if (rec_valid)
                     o_end_addr <= i_rec_addr;
               end else if (i_key_pause) begin
                  state       <= S_REC_PAUSE;
                  o_rec_pause <= 1'b1;
               end
            end
            S_REC_PAUSE: begin
               if (i_key_stop) begin
                  state      <= S_IDLE;
                  o_rec_stop <= 1'b1;
                  o_has_rec  <= rec_valid;
                  if (rec_valid)
                     o_end_addr <= i_rec_addr;
               end else if (i_key_record) begin
                  state       <= S_REC;
                  o_rec_start <= 1'b1;
               end
            end
            S_PLAY: begin
               if (i_key_stop || play_done) begin
                  state      <= S_IDLE;
                  o_dsp_stop <= 1'b1;
               end else if (i_key_pause) begin
                  state       <= S_PLAY_PAUSE;
                  o_dsp_pause <= 1'b1;
               end
            end
            S_PLAY_PAUSE: begin
               if (i_key_stop) begin
                  state      <= S_IDLE;
                  o_dsp_stop <= 1'b1;
               end else if (i_key_play) begin
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
                  o_speed     <= speed_clamped;
                  o_fast      <= i_fast;
                  o_interpol  <= i_interpol;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // SRAM port mux from the registered state; only active recording writes.
   always_comb begin
      o_sram_addr = '0;
      o_sram_we_n = 1'b1;
      case (state)
         S_REC: begin
            o_sram_addr = i_rec_addr;
            o_sram_we_n = 1'b0;
         end
         S_REC_PAUSE:  o_sram_addr = i_rec_addr;
         S_PLAY:       o_sram_addr = i_dsp_addr;
         S_PLAY_PAUSE: o_sram_addr = i_dsp_addr;
         default: begin
            o_sram_addr = '0;
            o_sram_we_n = 1'b1;
         end
      endcase
   end

   assign o_state = state;

endmodule

// File: tb/tb_aud_ctrl.sv
// Directed bench for aud_ctrl: each step pushes the expected output snapshot
// to a queue, then the snapshot is popped and compared after the clock edge.
module tb_aud_ctrl;

   localparam int unsigned ADDR_W = 20;

   typedef struct packed {
      logic [2:0]        st;
      logic [5:0]        cmd;   // rec_start,rec_pause,rec_stop,dsp_start,dsp_pause,dsp_stop
      logic [ADDR_W-1:0] end_a;
      logic              has;
      logic [3:0]        spd;
      logic              fast;
      logic              interp;
      logic [ADDR_W-1:0] saddr;
      logic              we_n;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              key_record, key_play, key_pause, key_stop;
   logic [3:0]        speed;
   logic              fast, interpol;
   logic [ADDR_W-1:0] rec_addr, dsp_addr;
   logic              rec_start, rec_pause, rec_stop;
   logic              dsp_start, dsp_pause, dsp_stop;
   logic [3:0]        o_speed;
   logic              o_fast, o_interpol;
   logic [ADDR_W-1:0] end_addr, sram_addr;
   logic              has_rec, sram_we_n;
   logic [2:0]        state;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Expected register values after the upcoming edge.
   logic [ADDR_W-1:0] m_end;
   logic              m_has;
   logic [3:0]        m_spd;
   logic              m_fast, m_int;

   aud_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_key_record(key_record), .i_key_play(key_play),
      .i_key_pause(key_pause), .i_key_stop(key_stop),
      .i_speed(speed), .i_fast(fast), .i_interpol(interpol),
      .i_rec_addr(rec_addr), .i_dsp_addr(dsp_addr),
      .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
      .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
      .o_speed(o_speed), .o_fast(o_fast), .o_interpol(o_interpol),
      .o_end_addr(end_addr), .o_has_rec(has_rec),
      .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n), .o_state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [5:0] cmd);
      exp_t e;
      e.st     = st;
      e.cmd    = cmd;
      e.end_a  = m_end;
      e.has    = m_has;
      e.spd    = m_spd;
      e.fast   = m_fast;
      e.interp = m_int;
      case (st)
         3'd1, 3'd2: e.saddr = rec_addr;
         3'd3, 3'd4: e.saddr = dsp_addr;
         default:    e.saddr = '0;
      endcase
      e.we_n = (st != 3'd1);
      q.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      e = q.pop_front();
      chk({tag, ".state"},  32'(state), 32'(e.st));
      chk({tag, ".cmd"},    32'({rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}), 32'(e.cmd));
      chk({tag, ".end"},    32'(end_addr), 32'(e.end_a));
      chk({tag, ".has"},    32'(has_rec), 32'(e.has));
      chk({tag, ".cfg"},    32'({o_speed, o_fast, o_interpol}), 32'({e.spd, e.fast, e.interp}));
      chk({tag, ".saddr"},  32'(sram_addr), 32'(e.saddr));
      chk({tag, ".we_n"},   32'(sram_we_n), 32'(e.we_n));
   endtask

   // One clock step: keys already driven are pulsed for exactly this edge.
   task automatic tick(input string tag, input logic [2:0] st, input logic [5:0] cmd);
      push(st, cmd);
      @(posedge clk);
      #1;
      key_record = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
      check(tag);
   endtask

   task automatic now(input string tag, input logic [2:0] st, input logic [5:0] cmd);
      push(st, cmd);
      check(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      key_record = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
      speed = 4'd0; fast = 1'b0; interpol = 1'b0;
      rec_addr = '1; dsp_addr = '0;
      m_end = '0; m_has = 1'b0; m_spd = 4'd1; m_fast = 1'b0; m_int = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      now("reset", 3'd0, 6'b000000);
      rst_n = 1'b1;

      // play without a recording is ignored
      key_play = 1'b1;   tick("play_norec", 3'd0, 6'b000000);
      // record then stop with nothing written
      key_record = 1'b1; tick("rec_empty", 3'd1, 6'b100000);
      key_stop = 1'b1;   tick("stop_empty", 3'd0, 6'b001000);

      // record to 0x100 and stop
      key_record = 1'b1; tick("rec1", 3'd1, 6'b100000);
      rec_addr = 20'h00100;
      tick("rec1_hold", 3'd1, 6'b000000);
      key_stop = 1'b1; m_end = 20'h00100; m_has = 1'b1;
      tick("stop1", 3'd0, 6'b001000);
      tick("stop1_after", 3'd0, 6'b000000);

      // play with speed 0 -> latched as 1
      dsp_addr = '0; speed = 4'd0; fast = 1'b1; interpol = 1'b0;
      key_play = 1'b1; m_spd = 4'd1; m_fast = 1'b1; m_int = 1'b0;
      tick("play1", 3'd3, 6'b000100);
      dsp_addr = 20'h00080;
      tick("ramp1", 3'd3, 6'b000000);
      key_pause = 1'b1; tick("ppause", 3'd4, 6'b000010);
      speed = 4'd5; tick("ppause_hold", 3'd4, 6'b000000);
      key_play = 1'b1; m_spd = 4'd5;
      tick("presume", 3'd3, 6'b000100);
      dsp_addr = 20'h000FF; tick("ramp2", 3'd3, 6'b000000);
      dsp_addr = 20'h00100; tick("end_stop", 3'd0, 6'b000001);
      tick("end_after", 3'd0, 6'b000000);

      // speed above 8 clamps to 8; manual stop from PLAY
      dsp_addr = '0; speed = 4'd12; fast = 1'b0; interpol = 1'b1;
      key_play = 1'b1; m_spd = 4'd8; m_fast = 1'b0; m_int = 1'b1;
      tick("play_clamp", 3'd3, 6'b000100);
      speed = 4'd2;
      key_stop = 1'b1; tick("play_stop", 3'd0, 6'b000001);

      // pause and stop together in REC -> stop wins
      rec_addr = 20'h00200;
      key_record = 1'b1; tick("rec2", 3'd1, 6'b100000);
      key_pause = 1'b1; key_stop = 1'b1; m_end = 20'h00200;
      tick("rec_ps", 3'd0, 6'b001000);

      // pause/resume, then auto stop at MAX_ADDR
      key_record = 1'b1; tick("rec3", 3'd1, 6'b100000);
      key_pause = 1'b1;  tick("rpause", 3'd2, 6'b010000);
      key_play = 1'b1;   tick("rpause_play", 3'd2, 6'b000000);
      key_record = 1'b1; tick("rresume", 3'd1, 6'b100000);
      rec_addr = 20'hFFFFE; m_end = 20'hFFFFE;
      tick("auto_stop", 3'd0, 6'b001000);

      // stop from REC_PAUSE with nothing written clears has_rec
      rec_addr = '1;
      key_record = 1'b1; tick("rec4", 3'd1, 6'b100000);
      key_pause = 1'b1;  tick("rpause4", 3'd2, 6'b010000);
      key_stop = 1'b1; m_has = 1'b0;
      tick("rpstop_empty", 3'd0, 6'b001000);

      // stop from REC_PAUSE with data records the length
      rec_addr = 20'h00300;
      key_record = 1'b1; tick("rec5", 3'd1, 6'b100000);
      key_pause = 1'b1;  tick("rpause5", 3'd2, 6'b010000);
      key_stop = 1'b1; m_end = 20'h00300; m_has = 1'b1;
      tick("rpstop5", 3'd0, 6'b001000);

      // asynchronous reset while playing
      dsp_addr = 20'h00010; speed = 4'd3; fast = 1'b1; interpol = 1'b0;
      key_play = 1'b1; m_spd = 4'd3; m_fast = 1'b1; m_int = 1'b0;
      tick("play6", 3'd3, 6'b000100);
      #2;
      rst_n = 1'b0;
      #1;
      m_end = '0; m_has = 1'b0; m_spd = 4'd1; m_fast = 1'b0; m_int = 1'b0;
      now("async_rst", 3'd0, 6'b000000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
